wm_input_conditioner: RTL and testbench

//  Front-end stage feeding washing_machine_top. Synchronises and debounces the raw

---
 rtl/wm_input_conditioner_pkg.sv | 23 ++
 rtl/wm_sync_debounce.sv | 55 +++++
 rtl/wm_input_conditioner.sv | 191 +++++++++++++++++++
 tb/tb_wm_input_conditioner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wm_input_conditioner_pkg.sv
// Shared definitions for the washing-machine input conditioner.
//   - Mode selector codes (MODE_*), matching the encoding of mode_raw/mode_select.
//   - Button FSM state encoding (BTN_*).
//   - max_int helper used to size the shared counter width.
package wm_input_conditioner_pkg;

  localparam logic [1:0] MODE_NORMAL   = 2'b00;
  localparam logic [1:0] MODE_DELICATE = 2'b01;
  localparam logic [1:0] MODE_HEAVY    = 2'b10;
  localparam logic [1:0] MODE_RINSE    = 2'b11;

  typedef enum logic [1:0] {
    BTN_REL        = 2'b00,
    BTN_PRESS_WAIT = 2'b01,
    BTN_PRESSED    = 2'b10,
    BTN_REL_WAIT   = 2'b11
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wm_sync_debounce.sv
// Synchroniser + stable-run detector for a WIDTH-bit raw input.
//   clk, reset  : clock, synchronous active-low reset
//   raw_i       : asynchronous raw input
//   sync_o      : value after SYNC_STAGES synchroniser flops
//   stable_o    : sync_o has held the same value for DEBOUNCE_CYCLES consecutive
//                 samples, counting the current one (combinational, so a consumer
//                 registering on it updates on the DEBOUNCE_CYCLES-th sample)
// Requires SYNC_STAGES >= 2 and DEBOUNCE_CYCLES >= 2.
module wm_sync_debounce #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             stable_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  last_q, last_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              same;

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign same   = (sync_o == last_q);
  // cnt_q is the run length of last_q; the current sample extends it when equal
  assign stable_o = same && (cnt_q >= CNT_LAST);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    last_d = sync_o;
    if (!same)                cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_TERM) cnt_d = cnt_q;  // saturate, never wrap
    else                      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/wm_input_conditioner.sv
// Front-end conditioner for washing_machine_top: synchronises and debounces the
// start/pause button, door switch and mode selector.
//   clk, reset        : clock, synchronous active-low reset
//   btn_raw           : raw button, 1 = pressed
//   door_raw          : raw door switch, 1 = closed
//   mode_raw[1:0]     : raw mode selector
//   start_pause_pulse : one-cycle pulse per accepted press
//   door_closed       : debounced door level (opens fast, closes slow)
//   door_event        : one-cycle pulse coincident with any door_closed change
//   mode_select[1:0]  : debounced mode
//   cancel_pulse      : one-cycle pulse on a long press
// Optional feature macro: WM_LONG_PRESS_EN builds the long-press hold counter;
// without it cancel_pulse is tied to 0.
module wm_input_conditioner
  import wm_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       door_raw,
  input  logic [1:0] mode_raw,
  output logic       start_pause_pulse,
  output logic       door_closed,
  output logic       door_event,
  output logic [1:0] mode_select,
  output logic       cancel_pulse
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------- button: synchroniser + debounce FSM ----------------
  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic                   btn_s;
  btn_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;

  assign btn_s = btn_sync_q[SYNC_STAGES-1];

  // The counter holds the number of samples already seen at the new level, so
  // entering a wait state loads 1 and the transition fires on the
  // DEBOUNCE_CYCLES-th consecutive sample.
  always_comb begin
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    case (state_q)
      BTN_REL: begin
        if (btn_s) begin
          state_d = BTN_PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      BTN_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = BTN_REL;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = BTN_PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BTN_PRESSED: begin
        if (!btn_s) begin
          state_d = BTN_REL_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      default: begin  // BTN_REL_WAIT
        if (btn_s) begin
          state_d = BTN_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = BTN_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Reset lands in REL_WAIT: a button held through reset must be seen released
  // for a full debounce window before it can produce a pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_sync_q <= '0;
      state_q    <= BTN_REL_WAIT;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      btn_sync_q <= btn_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign start_pause_pulse = pulse_q;

`ifdef WM_LONG_PRESS_EN
  // Hold counter: armed (cleared) by an accepted press, counts cycles spent in
  // PRESSED, fires once on reaching LONG_PRESS_CYCLES and then parks there.
  // It resets parked so a press carried through reset never cancels.
  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             cancel_q, cancel_d;

  always_comb begin
    hold_d   = hold_q;
    cancel_d = 1'b0;
    if (state_q == BTN_PRESSED && hold_q != LP_TERM) begin
      hold_d   = hold_q + 1'b1;
      cancel_d = (hold_q == LP_LAST);
    end
    if (pulse_d) hold_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q   <= LP_TERM;
      cancel_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      cancel_q <= cancel_d;
    end
  end

  assign cancel_pulse = cancel_q;
`else
  assign cancel_pulse = 1'b0;
`endif

  // ---------------- door: fast open, debounced close ----------------
  logic door_s, door_stable;
  logic door_closed_q, door_closed_d;
  logic door_event_q, door_event_d;

  wm_sync_debounce #(
    .WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_door (
    .clk(clk), .reset(reset), .raw_i(door_raw), .sync_o(door_s), .stable_o(door_stable)
  );

  // A synced 0 opens immediately; closing needs a full stable run of 1s.
  always_comb begin
    door_closed_d = door_s & (door_closed_q | door_stable);
    door_event_d  = door_closed_d ^ door_closed_q;
  end

  // ---------------- mode: accept only a value held for a full window ----------------
  logic [1:0] mode_s;
  logic       mode_stable;
  logic [1:0] mode_q, mode_d;

  wm_sync_debounce #(
    .WIDTH(2), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode (
    .clk(clk), .reset(reset), .raw_i(mode_raw), .sync_o(mode_s), .stable_o(mode_stable)
  );

  always_comb mode_d = mode_stable ? mode_s : mode_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      door_closed_q <= 1'b0;
      door_event_q  <= 1'b0;
      mode_q        <= MODE_NORMAL;
    end else begin
      door_closed_q <= door_closed_d;
      door_event_q  <= door_event_d;
      mode_q        <= mode_d;
    end
  end

  assign door_closed = door_closed_q;
  assign door_event  = door_event_q;
  assign mode_select = mode_q;

endmodule

// File: tb/tb_wm_input_conditioner.sv
module tb_wm_input_conditioner;
  localparam int S = 2, D = 16, L = 64;

  logic clk = 1'b0;
  logic reset, btn_raw, door_raw;
  logic [1:0] mode_raw;
  logic start_pause_pulse, door_closed, door_event, cancel_pulse;
  logic [1:0] mode_select;

  always #5 clk = ~clk;

  wm_input_conditioner #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .door_raw(door_raw),
    .mode_raw(mode_raw), .start_pause_pulse(start_pause_pulse),
    .door_closed(door_closed), .door_event(door_event),
    .mode_select(mode_select), .cancel_pulse(cancel_pulse)
  );

  int checks = 0, failures = 0, cyc = 0;

  // reference model: raw inputs reach the logic S clocks late; each output
  // follows from run lengths of identical synced samples
  bit         q_b[$], q_d[$];
  logic [1:0] q_m[$];
  bit         prev_b, prev_d, armed;
  logic [1:0] prev_m;
  int         run_b, run_d, run_m;
  bit         exp_sp, exp_dc, exp_ev, exp_cn;
  logic [1:0] exp_mode;
`ifdef WM_LONG_PRESS_EN
  int hold;
  bit pressed_prev;
`endif

  // observation bookkeeping for directed latency checks
  int sp_cnt, sp_last, cn_cnt, cn_last, ev_cnt, dc_rise, dc_fall;
  bit saw01;
  logic dc_prev = 1'b0;

  task automatic model_reset();
    q_b.delete(); q_d.delete(); q_m.delete();
    repeat (S) begin q_b.push_back(1'b0); q_d.push_back(1'b0); q_m.push_back(2'b00); end
    prev_b = 0; prev_d = 0; prev_m = 2'b00; armed = 0;
    run_b = 0; run_d = 0; run_m = 0;
    exp_sp = 0; exp_dc = 0; exp_ev = 0; exp_cn = 0; exp_mode = 2'b00;
`ifdef WM_LONG_PRESS_EN
    hold = L; pressed_prev = 0;
`endif
  endtask

  task automatic model_edge();
    bit sb, sd, new_dc;
    logic [1:0] sm;
    cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      q_b.push_back(btn_raw);  sb = q_b.pop_front();
      q_d.push_back(door_raw); sd = q_d.pop_front();
      q_m.push_back(mode_raw); sm = q_m.pop_front();
      run_b = (sb == prev_b) ? run_b + 1 : 1; prev_b = sb;
      run_d = (sd == prev_d) ? run_d + 1 : 1; prev_d = sd;
      run_m = (sm == prev_m) ? run_m + 1 : 1; prev_m = sm;
      exp_sp = 0; exp_cn = 0;
`ifdef WM_LONG_PRESS_EN
      if (pressed_prev && hold < L) begin
        hold++;
        if (hold == L) exp_cn = 1;
      end
`endif
      if (armed && sb && run_b >= D) begin
        exp_sp = 1; armed = 0;
`ifdef WM_LONG_PRESS_EN
        hold = 0;
`endif
      end else if (!armed && !sb && run_b >= D) begin
        armed = 1;
      end
`ifdef WM_LONG_PRESS_EN
      pressed_prev = !armed && sb;
`endif
      new_dc = sd ? (exp_dc || run_d >= D) : 1'b0;
      exp_ev = (new_dc != exp_dc);
      exp_dc = new_dc;
      if (run_m >= D) exp_mode = sm;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("start_pause_pulse", start_pause_pulse, exp_sp);
    chk("door_closed", door_closed, exp_dc);
    chk("door_event", door_event, exp_ev);
    chk("mode_select", mode_select, exp_mode);
    chk("cancel_pulse", cancel_pulse, exp_cn);
    if (start_pause_pulse === 1'b1) begin sp_cnt++; sp_last = cyc; end
    if (cancel_pulse === 1'b1) begin cn_cnt++; cn_last = cyc; end
    if (door_event === 1'b1) ev_cnt++;
    if (door_closed !== dc_prev) begin
      if (door_closed === 1'b1) dc_rise = cyc; else dc_fall = cyc;
      dc_prev = door_closed;
    end
    if (mode_select === 2'b01) saw01 = 1;
  endtask

  int t0;

  initial begin
    model_reset();
    reset = 1'b0; btn_raw = 0; door_raw = 0; mode_raw = 2'b00;
    // reset state
    repeat (3) tick();
    chk("reset_door_closed", door_closed, 1'b0);
    chk("reset_mode", mode_select, 2'b00);
    reset = 1'b1;
    repeat (20) tick();

    // clean hold: one pulse, S+D after the edge
    sp_cnt = 0; t0 = cyc; btn_raw = 1;
    repeat (40) tick();
    chk("hold_pulse_count", sp_cnt, 1);
    chk("hold_pulse_latency", sp_last - t0, 18);

    // bounce then settle
    btn_raw = 0; repeat (20) tick();
    sp_cnt = 0;
    btn_raw = 1; repeat (3) tick();
    btn_raw = 0; repeat (3) tick();
    btn_raw = 1; repeat (3) tick();
    btn_raw = 0; repeat (3) tick();
    t0 = cyc; btn_raw = 1;
    repeat (30) tick();
    chk("bounce_pulse_count", sp_cnt, 1);
    chk("bounce_pulse_latency", sp_last - t0, 18);

    // reset mid-press discards the press
    btn_raw = 0; repeat (20) tick();
    btn_raw = 1; repeat (10) tick();
    reset = 0; repeat (2) tick(); reset = 1;
    sp_cnt = 0; repeat (40) tick();
    chk("reset_midpress_no_pulse", sp_cnt, 0);
    btn_raw = 0; repeat (20) tick();
    sp_cnt = 0; btn_raw = 1; repeat (25) tick();
    chk("after_reset_press_count", sp_cnt, 1);
    btn_raw = 0; repeat (20) tick();

    // door: slow close, fast open
    ev_cnt = 0; t0 = cyc; door_raw = 1;
    repeat (30) tick();
    chk("door_rise_latency", dc_rise - t0, 18);
    t0 = cyc; door_raw = 0;
    repeat (10) tick();
    chk("door_fall_latency", dc_fall - t0, 3);
    chk("door_event_count", ev_cnt, 2);

    // mode glitch through 01 must never appear
    saw01 = 0;
    mode_raw = 2'b01; repeat (5) tick();
    mode_raw = 2'b10; repeat (30) tick();
    chk("mode_final", mode_select, 2'b10);
    chk("mode_no_01", saw01, 1'b0);

    // long press
    sp_cnt = 0; cn_cnt = 0; t0 = cyc; btn_raw = 1;
    repeat (100) tick();
    chk("long_press_pulse_latency", sp_last - t0, 18);
`ifdef WM_LONG_PRESS_EN
    chk("cancel_count", cn_cnt, 1);
    chk("cancel_latency", cn_last - t0, 18 + 64);
`else
    chk("cancel_absent", cn_cnt, 0);
`endif
    btn_raw = 0; repeat (20) tick();

    // randomized segments checked cycle by cycle against the model
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 0; repeat ($urandom_range(1, 3)) tick(); reset = 1;
      end
      btn_raw  = $urandom_range(0, 1);
      door_raw = $urandom_range(0, 1);
      mode_raw = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
